// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Snoops the multiplexed 8-digit 7-segment scan bus, decodes each
//            segment pattern back to BCD, reassembles the HH:MM:SS frame and
//            publishes it with a one-cycle strobe and a lock indicator.
// Ports    : clk, rst (async, active-high)
//            seg_com[7:0]  active-low digit select (bit7 = h_ten ... bit2 =
//                          s_one, bit1/bit0 = blank digits)
//            seg_data[7:0] active-high segments a..g,dp (bit7..bit0)
//            h_ten..s_one  last published BCD digits
//            new_time      strobe, digit outputs just updated
//            locked        level, tracking a good scan
//            code_err, com_err, seq_err  one-cycle error strobes
// Options  : SEG_DECODE_RANGE_CHECK_EN - reject frames whose time is not a
//            legal 24-hour clock value before publishing.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int TIMEOUT = 16,     // idle cycles before lock is dropped, 2..255
    parameter bit DP_MASK = 1'b1    // 1: ignore dp bit, 0: dp set is invalid
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_com,
    input  logic [7:0] seg_data,
    output logic [3:0] h_ten,
    output logic [3:0] h_one,
    output logic [3:0] m_ten,
    output logic [3:0] m_one,
    output logic [3:0] s_ten,
    output logic [3:0] s_one,
    output logic       new_time,
    output logic       locked,
    output logic       code_err,
    output logic       com_err,
    output logic       seq_err
);

    localparam logic [1:0] S_SYNC    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_PUBLISH = 2'd2;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);
    localparam logic [2:0] c_LAST    = 3'd5;   // position of s_one

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0] com_q,  data_q;
    logic [1:0] state_q, state_d;
    logic [2:0] exp_q,   exp_d;
    logic [7:0] idle_q,  idle_d;
    logic [3:0] shadow_q [6];
    logic [3:0] shadow_d [6];
    logic [3:0] out_q    [6];
    logic [3:0] out_d    [6];
    logic       new_time_q, new_time_d;
    logic       locked_q,   locked_d;
    logic       code_err_q, code_err_d;
    logic       com_err_q,  com_err_d;
    logic       seq_err_q,  seq_err_d;

    // ------------------------------------------------------------------
    // Slot classification of the registered digit select
    // ------------------------------------------------------------------
    logic [3:0] w_nlow;
    logic [2:0] w_pos;
    logic       w_idle, w_multi, w_active, w_time_slot;

    always_comb begin
        w_nlow = 4'd0;
        w_pos  = 3'd0;
        // Position 0 is bit7 (h_ten), position 7 is bit0 (blank7).
        for (int i = 0; i < 8; i++) begin
            if (!com_q[7-i]) begin
                w_nlow = w_nlow + 4'd1;
                w_pos  = 3'(i);
            end
        end
        w_idle      = (com_q == 8'hFF);
        w_multi     = (w_nlow > 4'd1);
        w_active    = (w_nlow == 4'd1);
        w_time_slot = w_active && (w_pos < 3'd6);
    end

    // ------------------------------------------------------------------
    // Segment pattern -> BCD
    // ------------------------------------------------------------------
    logic [7:0] w_pat;
    logic       w_valid;
    logic [3:0] w_bcd;

    always_comb begin
        // With DP_MASK clear, a lit dp never matches the table below.
        w_pat   = DP_MASK ? {data_q[7:1], 1'b0} : data_q;
        w_valid = 1'b1;
        w_bcd   = 4'd0;
        case (w_pat)
            8'hFC:   w_bcd = 4'd0;
            8'h60:   w_bcd = 4'd1;
            8'hDA:   w_bcd = 4'd2;
            8'hF2:   w_bcd = 4'd3;
            8'h66:   w_bcd = 4'd4;
            8'hB6:   w_bcd = 4'd5;
            8'hBE:   w_bcd = 4'd6;
            8'hE0:   w_bcd = 4'd7;
            8'hFE:   w_bcd = 4'd8;
            8'hF6:   w_bcd = 4'd9;
            default: w_valid = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Legal-time check of the frame about to be published. s_one needs no
    // check, so only the already-stored shadow digits are inspected.
    // ------------------------------------------------------------------
    logic w_range_ok;

    always_comb begin
`ifdef SEG_DECODE_RANGE_CHECK_EN
        w_range_ok = ((shadow_q[0] < 4'd2) ||
                      ((shadow_q[0] == 4'd2) && (shadow_q[1] <= 4'd3))) &&
                     (shadow_q[2] <= 4'd5) &&
                     (shadow_q[4] <= 4'd5);
`else
        w_range_ok = 1'b1;
`endif
    end

    // ------------------------------------------------------------------
    // Frame FSM, idle counter and strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        idle_d     = idle_q;
        shadow_d   = shadow_q;
        out_d      = out_q;
        new_time_d = 1'b0;
        locked_d   = locked_q;
        code_err_d = 1'b0;
        com_err_d  = 1'b0;
        seq_err_d  = 1'b0;

        // PUBLISH lasts one cycle; its slot is handled below as in SYNC.
        if (state_q == S_PUBLISH) begin
            state_d = S_SYNC;
        end

        if (w_idle) begin
            if (idle_q < c_TIMEOUT) begin
                idle_d = idle_q + 8'd1;
            end
        end else if (w_active) begin
            idle_d = 8'd0;
        end

        if (w_multi) begin
            com_err_d = 1'b1;
            locked_d  = 1'b0;
            state_d   = S_SYNC;
        end else if (w_idle && (idle_q == c_TIMEOUT - 8'd1)) begin
            locked_d = 1'b0;
            state_d  = S_SYNC;
        end else if (w_time_slot) begin
            if (state_q == S_COLLECT) begin
                if (w_pos == exp_q) begin
                    if (w_valid) begin
                        shadow_d[w_pos] = w_bcd;
                        exp_d           = exp_q + 3'd1;
                        if (exp_q == c_LAST) begin
                            // Outputs load on the edge entering PUBLISH so
                            // new_time and the new digits appear together.
                            if (w_range_ok) begin
                                for (int i = 0; i < 5; i++) begin
                                    out_d[i] = shadow_q[i];
                                end
                                out_d[5]   = w_bcd;
                                new_time_d = 1'b1;
                                locked_d   = 1'b1;
                                state_d    = S_PUBLISH;
                            end else begin
                                code_err_d = 1'b1;
                                locked_d   = 1'b0;
                                state_d    = S_SYNC;
                            end
                        end
                    end else begin
                        code_err_d = 1'b1;
                        locked_d   = 1'b0;
                        state_d    = S_SYNC;
                    end
                end else begin
                    seq_err_d = 1'b1;
                    locked_d  = 1'b0;
                    if ((w_pos == 3'd0) && w_valid) begin
                        shadow_d[0] = w_bcd;
                        exp_d       = 3'd1;
                        state_d     = S_COLLECT;
                    end else begin
                        state_d = S_SYNC;
                    end
                end
            end else if ((w_pos == 3'd0) && w_valid) begin
                shadow_d[0] = w_bcd;
                exp_d       = 3'd1;
                state_d     = S_COLLECT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com_q      <= 8'hFF;
            data_q     <= 8'h00;
            state_q    <= S_SYNC;
            exp_q      <= 3'd0;
            idle_q     <= 8'd0;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= 4'd0;
                out_q[i]    <= 4'd0;
            end
            new_time_q <= 1'b0;
            locked_q   <= 1'b0;
            code_err_q <= 1'b0;
            com_err_q  <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            com_q      <= seg_com;
            data_q     <= seg_data;
            state_q    <= state_d;
            exp_q      <= exp_d;
            idle_q     <= idle_d;
            shadow_q   <= shadow_d;
            out_q      <= out_d;
            new_time_q <= new_time_d;
            locked_q   <= locked_d;
            code_err_q <= code_err_d;
            com_err_q  <= com_err_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign h_ten    = out_q[0];
    assign h_one    = out_q[1];
    assign m_ten    = out_q[2];
    assign m_one    = out_q[3];
    assign s_ten    = out_q[4];
    assign s_one    = out_q[5];
    assign new_time = new_time_q;
    assign locked   = locked_q;
    assign code_err = code_err_q;
    assign com_err  = com_err_q;
    assign seq_err  = seq_err_q;

endmodule
`default_nettype wire
